// File: rtl/zuss_pkg.sv
// Shared widths and requester ids for the writeback arbiter slice.
package zuss_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int REG_N  = 2 ** REG_AW;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;
endpackage

// File: rtl/zuss_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = ALU, bit 1 = LSU.
module zuss_rr_arb2
  import zuss_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    // every grant is a completed transfer
    if (gnt[0]) begin
      last_d = REQ_ALU;
    end else if (gnt[1]) begin
      last_d = REQ_LSU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/zuss_wb_arbiter.sv
// ALU/LSU writeback arbiter with registered regfile port.
// Optional pending-write scoreboard enabled by ZUSS_WB_SCOREBOARD_EN.
module zuss_wb_arbiter #(
  parameter int XLEN = zuss_pkg::XLEN,
  parameter int AW   = zuss_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            we,
  output logic [AW-1:0]   w_addr,
  output logic [XLEN-1:0] w_data,
  input  logic            issue_set,
  input  logic [AW-1:0]   issue_addr,
  input  logic [AW-1:0]   chk_addr1,
  input  logic [AW-1:0]   chk_addr2,
  output logic            busy1,
  output logic            busy2
);

  logic [1:0]      gnt;
  logic [AW-1:0]   acc_addr;
  logic [XLEN-1:0] acc_data;

  logic            we_q, we_d;
  logic [AW-1:0]   w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;

  zuss_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({lsu_valid, alu_valid}),
    .gnt (gnt)
  );

  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];

  always_comb begin
    acc_addr = gnt[1] ? lsu_addr : alu_addr;
    acc_data = gnt[1] ? lsu_data : alu_data;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    // r0 writes are consumed but never reach the regfile
    we_d     = (|gnt) && (acc_addr != '0);
    if (|gnt) begin
      w_addr_d = acc_addr;
      w_data_d = acc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      we_q     <= we_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign we     = we_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

`ifdef ZUSS_WB_SCOREBOARD_EN
  localparam int N = 2 ** AW;

  logic [N-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[w_addr_q] = 1'b0;
    end
    // set after clear so a same-edge issue wins
    if (issue_set && (issue_addr != '0)) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1 = busy_q[chk_addr1];
  assign busy2 = busy_q[chk_addr2];
`else
  logic unused_sb;

  assign unused_sb = ^{issue_set, issue_addr, chk_addr1, chk_addr2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule
